// File: rtl/fft_frame_feeder.sv
// Converts 24-bit audio samples to FFT complex input words and frames them with LAST.
// A registered output stage with a one-entry skid buffer keeps full throughput; flush zero-pads a partial frame.
module fft_frame_feeder #(
  parameter int FRAME_LEN = 256,
  parameter int CNT_W     = 16
) (
  input  logic             I_CLOCK,
  input  logic             I_RESETN,
  input  logic             S_I_DATA_VALID,
  output logic             S_O_DATA_READY,
  input  logic [23:0]      S_I_DATA,
  input  logic             I_FLUSH,
  output logic             M_O_DATA_VALID,
  input  logic             M_I_DATA_READY,
  output logic [31:0]      M_O_DATA,
  output logic             M_O_DATA_LAST,
  output logic [CNT_W-1:0] O_FRAME_COUNT,
  output logic             O_PADDING
);

  typedef enum logic {ST_STREAM, ST_PAD} state_e;

  localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(FRAME_LEN - 1);

  // Takes S_I_DATA[23:7]: upper 16 bits plus the rounding bit.
  function automatic logic [15:0] round_sat(input logic [16:0] x);
    logic [15:0] hi;
    hi = x[16:1];
    if (hi == 16'h7FFF && x[0]) return 16'h7FFF;
    return hi + {15'd0, x[0]};
  endfunction

  state_e           state_q, state_d;
  logic             out_vld_q, out_vld_d;
  logic [15:0]      out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             skid_vld_q, skid_vld_d;
  logic [15:0]      skid_data_q, skid_data_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             flush_pend_q, flush_pend_d;
  logic             s_rdy_q, s_rdy_d;

  logic             acc;
  logic             out_free;
  logic             load;
  logic [15:0]      load_data;
  logic [15:0]      conv;

  always_comb begin
    state_d      = state_q;
    out_vld_d    = out_vld_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    skid_vld_d   = skid_vld_q;
    skid_data_d  = skid_data_q;
    idx_d        = idx_q;
    frame_cnt_d  = frame_cnt_q;
    flush_pend_d = flush_pend_q;
    load         = 1'b0;
    load_data    = 16'd0;

    acc      = S_I_DATA_VALID & s_rdy_q;
    out_free = ~out_vld_q | M_I_DATA_READY;
    conv     = round_sat(S_I_DATA[23:7]);

    if (out_free) begin
      out_vld_d  = 1'b0;
      out_last_d = 1'b0;
    end

    // Source priority for the output register: skid, then live input, then pad zeros.
    if (skid_vld_q) begin
      if (out_free) begin
        load       = 1'b1;
        load_data  = skid_data_q;
        skid_vld_d = 1'b0;
      end
    end else if (acc) begin
      if (out_free) begin
        load      = 1'b1;
        load_data = conv;
      end else begin
        skid_vld_d  = 1'b1;
        skid_data_d = conv;
      end
    end else if (state_q == ST_PAD && idx_q != '0 && out_free) begin
      load      = 1'b1;
      load_data = 16'd0;
    end

    if (load) begin
      out_vld_d  = 1'b1;
      out_data_d = load_data;
      out_last_d = (idx_q == IDX_LAST);
      idx_d      = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    if (out_vld_q && out_last_q && M_I_DATA_READY) frame_cnt_d = frame_cnt_q + 1'b1;

    unique case (state_q)
      ST_STREAM: begin
        if (flush_pend_q) begin
          // Everything accepted is loaded; a frame that just completed needs no padding.
          if (!skid_vld_q && !acc) begin
            flush_pend_d = 1'b0;
            if (idx_q != '0) state_d = ST_PAD;
          end
        end else if (I_FLUSH && !(idx_d == '0 && !skid_vld_d)) begin
          flush_pend_d = 1'b1;
        end
      end
      ST_PAD: begin
        // idx back at 0 means the LAST zero is sitting in the output register.
        if (idx_q == '0 && out_free) state_d = ST_STREAM;
      end
      default: state_d = ST_STREAM;
    endcase

    s_rdy_d = ~skid_vld_d & (state_d == ST_STREAM) & ~flush_pend_d;
  end

  always_ff @(posedge I_CLOCK or negedge I_RESETN) begin
    if (!I_RESETN) begin
      state_q      <= ST_STREAM;
      out_vld_q    <= 1'b0;
      out_data_q   <= 16'd0;
      out_last_q   <= 1'b0;
      skid_vld_q   <= 1'b0;
      skid_data_q  <= 16'd0;
      idx_q        <= '0;
      frame_cnt_q  <= '0;
      flush_pend_q <= 1'b0;
      s_rdy_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_vld_q    <= out_vld_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      skid_vld_q   <= skid_vld_d;
      skid_data_q  <= skid_data_d;
      idx_q        <= idx_d;
      frame_cnt_q  <= frame_cnt_d;
      flush_pend_q <= flush_pend_d;
      s_rdy_q      <= s_rdy_d;
    end
  end

  assign S_O_DATA_READY = s_rdy_q;
  assign M_O_DATA_VALID = out_vld_q;
  assign M_O_DATA       = {16'h0000, out_data_q};
  assign M_O_DATA_LAST  = out_last_q;
  assign O_FRAME_COUNT  = frame_cnt_q;
  assign O_PADDING      = (state_q == ST_PAD);

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Directed bench for fft_frame_feeder with FRAME_LEN=8: streaming, rounding, backpressure, flush, reset.
module tb_fft_frame_feeder;

  localparam int FL = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic [23:0]   s_data = 24'd0;
  logic          flush = 1'b0;
  logic          m_ready = 1'b1;
  logic          rand_en = 1'b0;
  logic          s_ready;
  logic          m_valid;
  logic [31:0]   m_data;
  logic          m_last;
  logic [CW-1:0] fcnt;
  logic          padding;

  int checks = 0;
  int errors = 0;

  logic [33:0] q[$];

  fft_frame_feeder #(.FRAME_LEN(FL), .CNT_W(CW)) dut (
    .I_CLOCK        (clk),
    .I_RESETN       (rst_n),
    .S_I_DATA_VALID (s_valid),
    .S_O_DATA_READY (s_ready),
    .S_I_DATA       (s_data),
    .I_FLUSH        (flush),
    .M_O_DATA_VALID (m_valid),
    .M_I_DATA_READY (m_ready),
    .M_O_DATA       (m_data),
    .M_O_DATA_LAST  (m_last),
    .O_FRAME_COUNT  (fcnt),
    .O_PADDING      (padding)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    m_ready = rand_en ? ($urandom_range(0, 99) < 30) : 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [33:0] word(input logic pad, input logic last, input logic [31:0] d);
    return {pad, last, d};
  endfunction

  // Transfer log plus hold-while-stalled and ready-drop checks.
  logic        prev_stall = 1'b0;
  logic        prev_acc_stall = 1'b0;
  logic [31:0] prev_data = 32'd0;
  logic        prev_last = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) begin
        check("hold_valid", 64'(m_valid), 64'd1);
        check("hold_data", 64'(m_data), 64'(prev_data));
        check("hold_last", 64'(m_last), 64'(prev_last));
      end
      if (prev_acc_stall) check("skid_ready_fall", 64'(s_ready), 64'd0);
      if (padding) check("ready_in_pad", 64'(s_ready), 64'd0);
      if (m_valid && m_ready) q.push_back({padding, m_last, m_data});
      prev_stall     = m_valid && !m_ready;
      prev_data      = m_data;
      prev_last      = m_last;
      prev_acc_stall = s_valid && s_ready && m_valid && !m_ready;
    end else begin
      prev_stall     = 1'b0;
      prev_acc_stall = 1'b0;
    end
  end

  task automatic send(input logic [23:0] x);
    int k;
    s_valid = 1'b1;
    s_data  = x;
    k = 0;
    @(negedge clk);
    while (!s_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("send_accept", 64'(s_ready), 64'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_words(input int n);
    int k;
    k = 0;
    while (q.size() < n && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("word_count", 64'(q.size()), 64'(n));
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  logic [23:0] rvec [8];
  logic [15:0] rexp [8];

  initial begin
    rvec = '{24'h7FFFFF, 24'h000180, 24'hFFFF7F, 24'h800000, 24'h0, 24'h0, 24'h0, 24'h0};
    rexp = '{16'h7FFF, 16'h0002, 16'hFFFF, 16'h8000, 16'h0, 16'h0, 16'h0, 16'h0};

    #2;
    check("rst_ready", 64'(s_ready), 64'd0);
    check("rst_valid", 64'(m_valid), 64'd0);
    check("rst_data", 64'(m_data), 64'd0);
    check("rst_last", 64'(m_last), 64'd0);
    check("rst_fcnt", 64'(fcnt), 64'd0);
    check("rst_pad", 64'(padding), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_before_edge", 64'(s_ready), 64'd0);
    @(posedge clk);
    #1;
    check("ready_after_edge", 64'(s_ready), 64'd1);

    // Back-to-back frame
    for (int i = 1; i <= 8; i++) send(24'(i << 8));
    wait_words(8);
    for (int i = 0; i < 8 && i < q.size(); i++)
      check("stream_word", 64'(q[i]), 64'(word(1'b0, i == 7, 32'(i + 1))));
    @(posedge clk);
    #1;
    check("stream_fcnt", 64'(fcnt), 64'd1);
    q.delete();

    // Rounding and saturation, completing a second frame
    for (int i = 0; i < 8; i++) send(rvec[i]);
    wait_words(8);
    for (int i = 0; i < 8 && i < q.size(); i++)
      check("round_word", 64'(q[i]), 64'(word(1'b0, i == 7, {16'h0, rexp[i]})));
    @(posedge clk);
    #1;
    check("round_fcnt", 64'(fcnt), 64'd2);
    q.delete();

    // Random backpressure over 64 samples
    rand_en = 1'b1;
    for (int i = 0; i < 64; i++) send(24'((i + 1) << 8));
    wait_words(64);
    rand_en = 1'b0;
    for (int i = 0; i < 64 && i < q.size(); i++)
      check("bp_word", 64'(q[i]), 64'(word(1'b0, (i % 8) == 7, 32'(i + 1))));
    repeat (2) @(posedge clk);
    #1;
    check("bp_fcnt", 64'(fcnt), 64'd10);
    q.delete();

    // Flush after 3 samples
    send(24'h000900);
    send(24'h000A00);
    send(24'h000B00);
    pulse_flush();
    wait_words(8);
    if (q.size() >= 8) begin
      check("flush_w0", 64'(q[0]), 64'(word(1'b0, 1'b0, 32'h9)));
      check("flush_w1", 64'(q[1]), 64'(word(1'b0, 1'b0, 32'hA)));
      check("flush_w2", 64'(q[2]), 64'(word(1'b0, 1'b0, 32'hB)));
      for (int i = 3; i < 8; i++)
        check("flush_zero", 64'(q[i]), 64'(word(1'b1, i == 7, 32'h0)));
    end
    @(posedge clk);
    #1;
    check("flush_fcnt", 64'(fcnt), 64'd11);
    check("flush_pad_end", 64'(padding), 64'd0);
    @(posedge clk);
    #1;
    check("flush_ready_back", 64'(s_ready), 64'd1);
    q.delete();

    // Flush at a frame boundary does nothing
    pulse_flush();
    repeat (10) @(posedge clk);
    #1;
    check("bnd_words", 64'(q.size()), 64'd0);
    check("bnd_pad", 64'(padding), 64'd0);
    check("bnd_fcnt", 64'(fcnt), 64'd11);
    check("bnd_ready", 64'(s_ready), 64'd1);

    // Reset mid-frame with a word held in the output register
    for (int i = 1; i <= 5; i++) send(24'(i << 8));
    check("pre_rst_valid", 64'(m_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(m_valid), 64'd0);
    check("mid_rst_data", 64'(m_data), 64'd0);
    check("mid_rst_last", 64'(m_last), 64'd0);
    check("mid_rst_ready", 64'(s_ready), 64'd0);
    check("mid_rst_fcnt", 64'(fcnt), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    for (int i = 1; i <= 8; i++) send(24'((i + 16) << 8));
    wait_words(8);
    for (int i = 0; i < 8 && i < q.size(); i++)
      check("post_rst_word", 64'(q[i]), 64'(word(1'b0, i == 7, 32'(i + 17))));
    @(posedge clk);
    #1;
    check("post_rst_fcnt", 64'(fcnt), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
